// File: rtl/mig_rst_seq.sv
// ----------------------------------------------------------------------------
// mig_rst_seq
//
// Power-up clock/reset sequencer for the clk_100m domain.
//   1. Holds the Si5338 I2C config engine in reset until the system PLL locks.
//   2. Waits for the config engine to report done (or error/timeout).
//   3. Holds the MIG sys_rst low for SETTLE_CYCLES while the Si5338 clock settles.
//   4. Releases the MIG reset and waits for init_calib_complete.
// Config failures and calibration timeouts/losses trigger a retry. After
// MAX_RETRY failed attempts the block parks in a sticky FAULT state. A PLL
// lock loss restarts the whole sequence and is not counted as a failure.
//
// Ports
//   i_clk          100 MHz system clock
//   i_reset_n      synchronous, active-low reset
//   i_pll_locked   syspll locked (asynchronous, synchronised here)
//   i_cfg_done     Si5338 config complete (i_clk domain, level)
//   i_cfg_error    Si5338 I2C NACK/error (i_clk domain, level)
//   i_calib_done   MIG init_calib_complete (asynchronous, synchronised here)
//   o_cfg_reset    active-high reset to the Si5338 config engine
//   o_mig_rst_n    active-low MIG sys_rst
//   o_ready        clocks configured and DDR3 calibrated
//   o_fault        sticky: retries exhausted
//   o_retry_cnt    failed attempts since reset / PLL relock (saturates at 15)
//   o_state        FSM state, debug (IDLE=0 CFG=1 SETTLE=2 MIG_RUN=3
//                  READY=4 RETRY=5 FAULT=6)
//
// Handshakes: there are no valid/ready pairs here; all inputs are levels
// that are sampled every cycle, and all outputs are registered levels.
// ----------------------------------------------------------------------------
module mig_rst_seq #(
    parameter int unsigned SETTLE_CYCLES = 1_000_000,
    parameter int unsigned CFG_TIMEOUT   = 10_000_000,
    parameter int unsigned CALIB_TIMEOUT = 50_000_000,
    parameter int unsigned RST_PULSE     = 16,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_pll_locked,
    input  logic       i_cfg_done,
    input  logic       i_cfg_error,
    input  logic       i_calib_done,
    output logic       o_cfg_reset,
    output logic       o_mig_rst_n,
    output logic       o_ready,
    output logic       o_fault,
    output logic [3:0] o_retry_cnt,
    output logic [2:0] o_state
);

    // Timer is wide enough to reach the largest duration minus one.
    localparam int unsigned MAX_A  = (SETTLE_CYCLES > CFG_TIMEOUT) ? SETTLE_CYCLES : CFG_TIMEOUT;
    localparam int unsigned MAX_B  = (CALIB_TIMEOUT > RST_PULSE) ? CALIB_TIMEOUT : RST_PULSE;
    localparam int unsigned MAX_T  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned TW     = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] CFG_LAST    = TW'(CFG_TIMEOUT - 1);
    localparam logic [TW-1:0] CALIB_LAST  = TW'(CALIB_TIMEOUT - 1);
    localparam logic [TW-1:0] PULSE_LAST  = TW'(RST_PULSE - 1);
    localparam logic [3:0]    MAX_RETRY_C = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CFG     = 3'd1,
        S_SETTLE  = 3'd2,
        S_MIG_RUN = 3'd3,
        S_READY   = 3'd4,
        S_RETRY   = 3'd5,
        S_FAULT   = 3'd6
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [TW-1:0] r_timer;
    logic [3:0]    r_retry_cnt;
    logic [3:0]    w_retry_next;

    logic          r_lock_q1;
    logic          r_lock_s;
    logic          r_calib_q1;
    logic          r_calib_s;

    logic          r_cfg_reset;
    logic          r_mig_rst_n;
    logic          r_ready;
    logic          r_fault;
    logic          w_cfg_reset_next;
    logic          w_mig_rst_n_next;
    logic          w_ready_next;
    logic          w_fault_next;
    logic          w_lock_lost;

    // Lock loss restarts the sequence from any active state; IDLE is already
    // waiting for lock and FAULT only leaves on reset.
    assign w_lock_lost = !r_lock_s && (r_state != S_IDLE) && (r_state != S_FAULT);

    always_comb begin
        w_next       = r_state;
        w_retry_next = r_retry_cnt;

        if (w_lock_lost) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_lock_s) w_next = S_CFG;
                end
                S_CFG: begin
                    // error wins over done, done wins over timeout
                    if (i_cfg_error)             w_next = S_RETRY;
                    else if (i_cfg_done)         w_next = S_SETTLE;
                    else if (r_timer == CFG_LAST) w_next = S_RETRY;
                end
                S_SETTLE: begin
                    if (i_cfg_error)                 w_next = S_RETRY;
                    else if (r_timer == SETTLE_LAST) w_next = S_MIG_RUN;
                end
                S_MIG_RUN: begin
                    if (r_calib_s)                  w_next = S_READY;
                    else if (r_timer == CALIB_LAST) w_next = S_RETRY;
                end
                S_READY: begin
                    if (!r_calib_s) w_next = S_RETRY;
                end
                S_RETRY: begin
                    // count was already bumped on entry; give up once it hits the limit
                    if (r_retry_cnt >= MAX_RETRY_C)  w_next = S_FAULT;
                    else if (r_timer == PULSE_LAST) w_next = S_CFG;
                end
                S_FAULT: begin
                    w_next = S_FAULT;
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end

        if (w_lock_lost) begin
            w_retry_next = 4'd0;
        end else if ((w_next == S_RETRY) && (r_state != S_RETRY) && (r_retry_cnt != 4'hF)) begin
            w_retry_next = r_retry_cnt + 4'd1;
        end

        // Outputs are decoded from the next state so the registers line up
        // with r_state without an extra cycle of lag.
        w_cfg_reset_next = (w_next == S_IDLE) || (w_next == S_RETRY) || (w_next == S_FAULT);
        w_mig_rst_n_next = (w_next == S_MIG_RUN) || (w_next == S_READY);
        w_ready_next     = (w_next == S_READY);
        w_fault_next     = (w_next == S_FAULT);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_retry_cnt <= 4'd0;
            r_lock_q1   <= 1'b0;
            r_lock_s    <= 1'b0;
            r_calib_q1  <= 1'b0;
            r_calib_s   <= 1'b0;
            r_cfg_reset <= 1'b1;
            r_mig_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_lock_q1   <= i_pll_locked;
            r_lock_s    <= r_lock_q1;
            r_calib_q1  <= i_calib_done;
            r_calib_s   <= r_calib_q1;
            r_state     <= w_next;
            r_retry_cnt <= w_retry_next;
            // cleared on every state change; saturates in the untimed states
            if (w_next != r_state) begin
                r_timer <= '0;
            end else if (r_timer != {TW{1'b1}}) begin
                r_timer <= r_timer + TW'(1);
            end
            r_cfg_reset <= w_cfg_reset_next;
            r_mig_rst_n <= w_mig_rst_n_next;
            r_ready     <= w_ready_next;
            r_fault     <= w_fault_next;
        end
    end

    assign o_cfg_reset = r_cfg_reset;
    assign o_mig_rst_n = r_mig_rst_n;
    assign o_ready     = r_ready;
    assign o_fault     = r_fault;
    assign o_retry_cnt = r_retry_cnt;
    assign o_state     = r_state;

endmodule
